// File: rtl/fifo_read_streamer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_streamer
// Brief    : Read-side engine for synchronous_fifo. Hides the FIFO's one-cycle
//            read latency behind a 2-entry skid buffer, presents a valid/ready
//            stream and offers a flush that drains and discards FIFO contents.
//            Optional delivered-word counter: FIFO_RD_STREAM_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_streamer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_r_en,
    input  logic [WIDTH-1:0] fifo_data_out,
    input  logic             fifo_empty,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    input  logic             flush,
    output logic             flush_done
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0] words_out
`endif
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [1:0]       r_occ;
    logic             r_inflight;
    logic [WIDTH-1:0] r_buf0;
    logic [WIDTH-1:0] r_buf1;
    logic             w_pop;
    logic [2:0]       w_level;

    // A pop is only possible in RUN; FLUSH keeps the buffer empty.
    assign w_pop   = (r_state == S_RUN) && (r_occ != 2'd0) && m_ready;
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign m_data  = r_buf0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN: begin
                if (flush) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fifo_empty && !r_inflight) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_comb begin
        m_valid    = 1'b0;
        fifo_r_en  = 1'b0;
        flush_done = 1'b0;
        case (r_state)
            S_RUN: begin
                m_valid   = (r_occ != 2'd0);
                fifo_r_en = !fifo_empty && (w_level < 3'd2);
            end
            S_FLUSH: begin
                fifo_r_en  = !fifo_empty;
                flush_done = fifo_empty && !r_inflight;
            end
            default: begin
                m_valid = 1'b0;
            end
        endcase
    end

    // Skid buffer: r_buf0 is the head, r_buf1 the second entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= fifo_r_en;
            if ((r_state == S_RUN) && !flush) begin
                case ({r_inflight, w_pop})
                    2'b11: begin
                        if (r_occ == 2'd2) begin
                            r_buf0 <= r_buf1;
                            r_buf1 <= fifo_data_out;
                        end else begin
                            r_buf0 <= fifo_data_out;
                        end
                    end
                    2'b10: begin
                        if (r_occ == 2'd0) begin
                            r_buf0 <= fifo_data_out;
                        end else begin
                            r_buf1 <= fifo_data_out;
                        end
                        r_occ <= r_occ + 2'd1;
                    end
                    2'b01: begin
                        r_buf0 <= r_buf1;
                        r_occ  <= r_occ - 2'd1;
                    end
                    default: begin
                        r_occ <= r_occ;
                    end
                endcase
            end else begin
                // Flush entry and the whole FLUSH state discard everything.
                r_occ <= 2'd0;
            end
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [CNT_W-1:0] r_words;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_words <= '0;
        end else if (w_pop) begin
            r_words <= r_words + 1'b1;
        end
    end

    assign words_out = r_words;
`else
    logic [CNT_W-1:0] w_cnt_unused;
    assign w_cnt_unused = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_streamer
// Brief    : Directed self-checking bench; a queue-based FIFO and an expected
//            word stream drive a per-cycle compare against fifo_read_streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_streamer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_r_en;
    logic [7:0] fifo_data_out = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       flush = 1'b0;
    logic       flush_done;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [3:0] words_out;
`endif

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int ren_cnt = 0;
    logic [7:0] last_acc = 8'h00;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    fifo_read_streamer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_r_en    (fifo_r_en),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .flush        (flush),
        .flush_done   (flush_done)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .words_out    (words_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO with one-cycle registered read data, plus the expected output stream:
    // every word written is expected out, except those discarded by flush or reset.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            fifo_data_out <= 8'h00;
            fifo_empty    <= 1'b1;
        end else begin
            if (fifo_r_en) begin
                check("fifo_underflow", 32'(fifo_q.size() == 0), 32'd0);
                if (fifo_q.size() != 0) fifo_data_out <= fifo_q.pop_front();
            end
            if (flush) exp_q.delete();
            if (wr_en) begin
                fifo_q.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    logic       prev_stall = 1'b0;
    logic       prev_rst   = 1'b1;
    logic       prev_flush = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            check("r_en_while_empty", 32'(fifo_r_en && fifo_empty), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
            check("words_out", 32'(words_out), 32'(acc_cnt % 16));
`endif
            if (prev_stall && !prev_rst && !prev_flush) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                acc_cnt++;
                last_acc = m_data;
            end
            if (fifo_r_en) ren_cnt++;
        end else begin
            acc_cnt = 0;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_rst   = rst;
        prev_flush = flush;
    end

    task automatic do_flush(input int exp_done_at);
        int done_at;
        int done_cnt;
        logic empty_at_done;
        done_at = -1;
        done_cnt = 0;
        empty_at_done = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid_drop", 32'(m_valid), 32'd0);
        for (int off = 1; off <= 20; off++) begin
            if (flush_done) begin
                done_cnt++;
                done_at = off;
                empty_at_done = fifo_empty;
            end
            tick();
        end
        check("flush_done_pulses", 32'(done_cnt), 32'd1);
        check("flush_done_cycle", 32'(done_at), 32'(exp_done_at));
        check("flush_fifo_empty", 32'(empty_at_done), 32'd1);
    endtask

    initial begin
        int a0;
        repeat (3) tick();
        check("rst_r_en", 32'(fifo_r_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check("rst_words_out", 32'(words_out), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Latency and back-to-back delivery of 0x11, 0x22, 0x33.
        m_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'h11;
        tick();
        check("lat_empty_fell", 32'(fifo_empty), 32'd0);
        check("lat_r_en", 32'(fifo_r_en), 32'd1);
        check("lat_valid_n", 32'(m_valid), 32'd0);
        wr_data = 8'h22;
        tick();
        check("lat_valid_n1", 32'(m_valid), 32'd0);
        wr_data = 8'h33;
        tick();
        wr_en = 1'b0;
        check("lat_valid_n2", 32'(m_valid), 32'd1);
        check("word0", 32'(m_data), 32'h11);
        tick();
        check("word1", 32'(m_data), 32'h22);
        tick();
        check("word2", 32'(m_data), 32'h33);
        tick();
        check("idle_after_3", 32'(m_valid), 32'd0);

        // Back-pressure: 8 words queued, consumer stalled for 10 cycles.
        m_ready = 1'b0;
        ren_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h40 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (10) tick();
        check("bp_r_en_pulses", 32'(ren_cnt), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_head", 32'(m_data), 32'h40);
        m_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("b2b_valid", 32'(m_valid), 32'd1);
            check("b2b_data", 32'(m_data), 32'h40 + 32'(j));
            tick();
        end
        check("b2b_done", 32'(m_valid), 32'd0);

        // m_ready toggling every cycle while streaming 0x00..0x07.
        a0 = acc_cnt;
        for (int i = 0; i < 30; i++) begin
            m_ready = i[0];
            wr_en = (i < 8);
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        m_ready = 1'b1;
        repeat (6) tick();
        check("toggle_delivered", 32'(acc_cnt - a0), 32'd8);
        check("toggle_exp_left", 32'(exp_q.size()), 32'd0);

        // Flush with 2 words buffered and 3 still in the FIFO.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'hB0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (4) tick();
        check("pre_flush_fifo", 32'(fifo_q.size()), 32'd3);
        check("pre_flush_head", 32'(m_data), 32'hB0);
        do_flush(5);
        m_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        repeat (5) tick();
        check("post_flush_word", 32'(last_acc), 32'hA5);
        check("post_flush_exp_left", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a stream with the buffer full.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hD0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (3) tick();
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_r_en", 32'(fifo_r_en), 32'd0);
        check("mid_rst_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check("mid_rst_words", 32'(words_out), 32'd0);
`endif
        m_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'hC1;
        tick();
        wr_data = 8'hC2;
        tick();
        wr_en = 1'b0;
        repeat (5) tick();
        check("resume_last", 32'(last_acc), 32'hC2);
        check("resume_exp_left", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
        // 17 deliveries wrap a 4-bit counter to 1; flushed words are not counted.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (6) tick();
        check("cnt_wrap", 32'(words_out), 32'd1);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'hE0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (4) tick();
        do_flush(3);
        check("cnt_after_flush", 32'(words_out), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
